// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and sequencer for the multiplexed external memory bus.
// Port D has priority; a starvation guard forces an I grant after two back-to-back D grants.
module mem_bus_arbiter #(
   parameter int WAIT_STATES = 1,
   parameter int W           = 16
) (
   input  logic         Clock,
   input  logic         nReset,
   input  logic         IReq,
   input  logic [W-1:0] IAddr,
   output logic         IAck,
   input  logic         DReq,
   input  logic         DWrite,
   input  logic [W-1:0] DAddr,
   input  logic [W-1:0] DWData,
   output logic         DAck,
   output logic [W-1:0] RData,
   output logic [W-1:0] ADOut,
   output logic         ADOe,
   input  logic [W-1:0] ADIn,
   output logic         ALE,
   output logic         nME,
   output logic         nOE,
   output logic         nWE,
   output logic         ENB,
   output logic         Busy,
   output logic         OwnerD
);

   typedef enum logic [2:0] {IDLE, ADDR, WAIT, XFER, END} BusState;

   BusState      state;
   BusState      nextState;
   logic [W-1:0] addrReg;
   logic [W-1:0] wDataReg;
   logic         writeReg;
   logic [2:0]   waitCnt;
   logic [1:0]   starveCnt;
   logic         anyReq;
   logic         grantD;

   assign anyReq = IReq | DReq;
   // D wins unless I has already been passed over twice in a row
   assign grantD = DReq & ~(IReq & (starveCnt == 2'd2));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state and Moore strobe decode; everything depends on registered state only
   always_comb begin
      nextState = state;
      ALE       = 1'b0;
      nME       = 1'b1;
      nOE       = 1'b1;
      nWE       = 1'b1;
      ENB       = 1'b0;
      ADOe      = 1'b0;
      ADOut     = '0;
      IAck      = 1'b0;
      DAck      = 1'b0;
      Busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (anyReq)
               nextState = ADDR;
         end
         ADDR: begin
            ALE   = 1'b1;
            nME   = 1'b0;
            ADOe  = 1'b1;
            ADOut = addrReg;
            nextState = (WAIT_STATES > 0) ? WAIT : XFER;
         end
         WAIT, XFER: begin
            nME = 1'b0;
            ENB = 1'b1;
            if (writeReg) begin
               nWE   = 1'b0;
               ADOe  = 1'b1;
               ADOut = wDataReg;
            end else begin
               nOE = 1'b0;
            end
            if (state == XFER)
               nextState = END;
            else if (waitCnt <= 3'd1)
               nextState = XFER;
         end
         END: begin
            IAck      = ~OwnerD;
            DAck      = OwnerD;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Grant-time latching, wait countdown, starvation tracking and read capture
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         addrReg   <= '0;
         wDataReg  <= '0;
         writeReg  <= 1'b0;
         waitCnt   <= 3'd0;
         starveCnt <= 2'd0;
         OwnerD    <= 1'b0;
         RData     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  OwnerD  <= grantD;
                  waitCnt <= 3'(WAIT_STATES);
                  if (grantD) begin
                     addrReg   <= DAddr;
                     wDataReg  <= DWData;
                     writeReg  <= DWrite;
                     starveCnt <= IReq ? (starveCnt + 2'd1) : 2'd0;
                  end else begin
                     addrReg   <= IAddr;
                     writeReg  <= 1'b0;
                     starveCnt <= 2'd0;
                  end
               end
            end
            WAIT: waitCnt <= waitCnt - 3'd1;
            XFER: begin
               if (!writeReg)
                  RData <= ADIn;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the multiplexed external memory bus between two requesters inside the processor core. The instruction-fetch port (I) is driven by the fetch sequence of the control unit; the data port (D) is driven by load/store execution. The block owns the external strobes ALE, nME, nOE, nWE and ENB and the address/data pad drive. Each granted request runs a fixed address, wait and transfer sequence, then returns a one-cycle acknowledge with read data.

## Interface
Parameters:
- WAIT_STATES, 1: extra access cycles between address and transfer phase. Legal range 0..7.
- W, 16: address and data width.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- IReq  in  1  instruction read request; held high until IAck.
- IAddr  in  W  instruction address; stable while IReq is high.
- IAck  out  1  one-cycle pulse; RData is valid for port I.
- DReq  in  1  data request; held high until DAck.
- DWrite  in  1  1 = write, 0 = read; stable while DReq is high.
- DAddr  in  W  data address.
- DWData  in  W  write data.
- DAck  out  1  one-cycle pulse; write done, or RData valid for port D.
- RData  out  W  read data register, shared by both ports.
- ADOut  out  W  value driven onto the multiplexed AD pads.
- ADOe  out  1  pad output enable for ADOut.
- ADIn  in  W  AD pad input.
- ALE  out  1  address latch enable, active high.
- nME  out  1  memory enable, active low.
- nOE  out  1  memory output enable, active low.
- nWE  out  1  memory write enable, active low.
- ENB  out  1  data buffer enable, active high.
- Busy  out  1  high in every state except IDLE.
- OwnerD  out  1  1 = current or last grant was to port D.

## Operation
- States: IDLE, ADDR, WAIT, XFER, END. Bus outputs are decoded from registered state only (Moore), so there are no glitches.
- IDLE: all strobes inactive (ALE=0, nME=1, nOE=1, nWE=1, ENB=0, ADOe=0).
  - If any request is high: arbitrate, latch address, direction and write data into internal registers, load the wait counter with WAIT_STATES, then go to ADDR.
  - Port I is always a read.
- ADDR: ALE=1, nME=0, ADOe=1, ADOut = latched address. Go to WAIT if WAIT_STATES>0, else to XFER.
- WAIT and XFER strobes:
  - Both states: nME=0, ENB=1.
  - Read: nOE=0, ADOe=0.
  - Write: nWE=0, ADOe=1, ADOut = latched write data.
- WAIT: decrement the counter each cycle; go to XFER when the counter reaches 1 (so WAIT lasts exactly WAIT_STATES cycles).
- XFER: same strobes as WAIT. On a read, RData <= ADIn at the closing edge. Go to END.
- END: all strobes inactive. Assert the granted port's Ack for this one cycle. Go to IDLE.
  - END never grants directly, so a requester sees its Ack before it is re-sampled.
- Arbitration:
  - Port D has priority.
  - Starvation guard: a 2-bit counter of consecutive D grants while IReq was high. When it reaches 2, the next arbitration grants I.
  - The counter clears on any I grant, and whenever IReq is low at arbitration.
- If Req drops mid-access, the access still completes and Ack still pulses. Latched values are used, so input changes after grant are ignored.
- RData holds its value until the next read transfer. A write does not change RData.

## Timing
- Reset values (asynchronous, immediate, including mid-access):
  - State = IDLE; strobes inactive (ALE=0, nME=1, nOE=1, nWE=1, ENB=0, ADOe=0).
  - ADOut=0, RData=0, IAck=0, DAck=0, Busy=0, OwnerD=0.
  - Starvation counter = 0.
- Latency: Req sampled high at edge k (state IDLE) gives:
  - ADDR after edge k;
  - XFER after edge k+1+WAIT_STATES;
  - Ack high after edge k+2+WAIT_STATES;
  - IDLE after edge k+3+WAIT_STATES.
- Minimum request-to-request period is 4+WAIT_STATES cycles.
- Ack is exactly one cycle wide. RData is valid in the Ack cycle and stays valid afterwards.
- Simultaneous IReq and DReq in IDLE: D is granted unless the starvation counter is 2.

## Test plan
- Reset then single read: WAIT_STATES=1, IReq, IAddr=0x0100, ADIn=0xBEEF during XFER.
  - Expect ALE for 1 cycle with ADOut=0x0100, then nOE low for 2 cycles.
  - Expect IAck pulse 3 cycles after grant edge, RData=0xBEEF, OwnerD=0.
- Data write: DReq, DWrite=1, DAddr=0x2000, DWData=0x1234.
  - Expect ADOut=0x1234 with nWE low and ADOe=1 for 1+WAIT_STATES cycles, nOE high throughout.
  - Expect DAck pulse; RData unchanged.
- Priority and starvation: IReq and DReq held high continuously, each requester re-asserting after its Ack.
  - Expected grant order: D, D, I, D, D, I.
- WAIT_STATES=0 and WAIT_STATES=7 builds:
  - XFER follows ADDR directly, respectively 7 WAIT cycles are inserted.
  - Ack arrives at edge k+2, respectively k+9.
- Async reset asserted during WAIT of a write:
  - All strobes go inactive without waiting for a clock edge; no Ack.
  - After release, a pending request restarts from ADDR.
- Input changes after grant: DAddr and DWData change during WAIT, and DReq drops before END.
  - Latched values remain on ADOut; DAck still pulses once.
